// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and coordinate helpers used by the
// sync generator and by the pixel-generation blocks that draw into the frame.
package vga_timing_pkg;

    localparam int HD = 640;
    localparam int HF = 16;
    localparam int HR = 96;
    localparam int HB = 48;
    localparam int H_TOTAL = HD + HF + HR + HB;

    localparam int VD = 480;
    localparam int VF = 10;
    localparam int VR = 2;
    localparam int VB = 33;
    localparam int V_TOTAL = VD + VF + VR + VB;

    localparam int MAX_X = HD;
    localparam int MAX_Y = VD;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
    } sync_t;

    // Inclusive window test used to place the active-low retrace pulses.
    function automatic logic in_window(coord_t value, coord_t first, coord_t last);
        return (value >= first) && (value <= last);
    endfunction

endpackage

// File: rtl/mod_m_tick.sv
// Free-running modulo-M counter that emits a one-clock tick on its last count.
module mod_m_tick #(
    parameter int M = 2
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int N = (M > 1) ? $clog2(M) : 1;
    localparam logic [N-1:0] LAST = N'(M - 1);

    logic [N-1:0] count_reg;
    logic [N-1:0] count_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    always_comb begin
        count_next = (count_reg == LAST) ? '0 : count_reg + N'(1);
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA horizontal/vertical sync generator: pixel-rate counters with registered,
// skew-free sync pulses and a frame-start strobe.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = HD,
    parameter int H_FRONT   = HF,
    parameter int H_RETRACE = HR,
    parameter int H_BACK    = HB,
    parameter int V_DISPLAY = VD,
    parameter int V_FRONT   = VF,
    parameter int V_RETRACE = VR,
    parameter int V_BACK    = VB
) (
    input  logic               clk,
    input  logic               reset,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_start
);

    localparam coord_t H_MAX     = coord_t'(H_DISPLAY + H_FRONT + H_RETRACE + H_BACK - 1);
    localparam coord_t V_MAX     = coord_t'(V_DISPLAY + V_FRONT + V_RETRACE + V_BACK - 1);
    localparam coord_t H_VISIBLE = coord_t'(H_DISPLAY);
    localparam coord_t V_VISIBLE = coord_t'(V_DISPLAY);
    localparam coord_t HS_FIRST  = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_LAST   = coord_t'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
    localparam coord_t VS_FIRST  = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_LAST   = coord_t'(V_DISPLAY + V_FRONT + V_RETRACE - 1);

    coord_t h_count;
    coord_t v_count;
    coord_t h_next;
    coord_t v_next;
    sync_t  sync_reg;
    sync_t  sync_next;
    logic   frame_wrap;

    mod_m_tick #(
        .M(2)
    ) u_pixel_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (p_tick)
    );

    always_comb begin
        h_next     = h_count;
        v_next     = v_count;
        frame_wrap = 1'b0;
        if (p_tick) begin
            if (h_count == H_MAX) begin
                h_next = '0;
                if (v_count == V_MAX) begin
                    v_next     = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_next = v_count + coord_t'(1);
                end
            end else begin
                h_next = h_count + coord_t'(1);
            end
        end
    end

    // Syncs are decoded from the next-state counts so they land on the same edge as pixel_x/pixel_y.
    always_comb begin
        sync_next.hsync = ~in_window(h_next, HS_FIRST, HS_LAST);
        sync_next.vsync = ~in_window(v_next, VS_FIRST, VS_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_count     <= '0;
            v_count     <= '0;
            sync_reg    <= '{hsync: 1'b1, vsync: 1'b1};
            frame_start <= 1'b0;
        end else begin
            h_count     <= h_next;
            v_count     <= v_next;
            sync_reg    <= sync_next;
            frame_start <= frame_wrap;
        end
    end

    assign pixel_x  = h_count;
    assign pixel_y  = v_count;
    assign hsync    = sync_reg.hsync;
    assign vsync    = sync_reg.vsync;
    assign video_on = (h_count < H_VISIBLE) && (v_count < V_VISIBLE);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: directed snapshots keyed by clock edge
// plus running sync/frame counters; vertical timing shrunk to 12 lines.
module tb_vga_sync_gen;

    localparam int TVD = 6;
    localparam int TVF = 2;
    localparam int TVR = 2;
    localparam int TVB = 2;
    localparam int FRAME_CLKS = 2 * 800 * (TVD + TVF + TVR + TVB);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_start;

    typedef struct {
        int   cyc;
        int   px;
        int   py;
        logic tick;
        logic hs;
        logic vs;
        logic von;
        logic fs;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    int   hs_low_cnt = 0;
    int   vs_low_cnt = 0;
    int   fs_cnt = 0;
    int   von_bad = 0;
    logic phase1 = 1'b0;
    logic running = 1'b0;

    vga_sync_gen #(
        .V_DISPLAY (TVD),
        .V_FRONT   (TVF),
        .V_RETRACE (TVR),
        .V_BACK    (TVB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .p_tick      (p_tick),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start)
    );

    always #10 clk = ~clk;

    // Edge index since the last reset edge; 0 means "just reset".
    always @(posedge clk) begin
        edge_n <= reset ? 0 : edge_n + 1;
    end

    task automatic check_output(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic push_exp(input int cyc, input int px, input int py, input logic tick,
                            input logic hs, input logic vs, input logic von, input logic fs);
        exp_t e;
        e.cyc  = cyc;
        e.px   = px;
        e.py   = py;
        e.tick = tick;
        e.hs   = hs;
        e.vs   = vs;
        e.von  = von;
        e.fs   = fs;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the expected snapshot for this edge and keeps running tallies.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
            mon_e = exp_q.pop_front();
            check_output($sformatf("n%0d pixel_x", mon_e.cyc), int'(pixel_x), mon_e.px);
            check_output($sformatf("n%0d pixel_y", mon_e.cyc), int'(pixel_y), mon_e.py);
            check_output($sformatf("n%0d p_tick", mon_e.cyc), int'(p_tick), int'(mon_e.tick));
            check_output($sformatf("n%0d hsync", mon_e.cyc), int'(hsync), int'(mon_e.hs));
            check_output($sformatf("n%0d vsync", mon_e.cyc), int'(vsync), int'(mon_e.vs));
            check_output($sformatf("n%0d video_on", mon_e.cyc), int'(video_on), int'(mon_e.von));
            check_output($sformatf("n%0d frame_start", mon_e.cyc), int'(frame_start), int'(mon_e.fs));
        end
        if (phase1) begin
            if (edge_n <= 1599 && !hsync) hs_low_cnt++;
            if (edge_n <= FRAME_CLKS - 1 && !vsync) vs_low_cnt++;
            if (edge_n <= 2 * FRAME_CLKS + 1 && frame_start) fs_cnt++;
        end
        if (running) begin
            if (video_on && (pixel_y >= 10'(TVD) || pixel_x >= 10'd640)) von_bad++;
            if (frame_start) begin
                check_output($sformatf("n%0d frame_start at origin", edge_n),
                             int'(pixel_x == 10'd0 && pixel_y == 10'd0 &&
                                  edge_n > 0 && (edge_n % FRAME_CLKS) == 0), 1);
            end
        end
    end

    task automatic wait_drain(input int budget);
        int b = budget;
        while (exp_q.size() > 0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (exp_q.size() > 0) begin
            check_output("scoreboard drain timeout, entries left", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic wait_edge(input int target, input int budget);
        int b = budget;
        while (edge_n != target && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (edge_n != target) check_output("wait for edge timeout", edge_n, target);
    endtask

    task automatic apply_stimulus();
        // Pixel index P = n/2: pixel_x = P%800, pixel_y = P/800 mod 12.
        push_exp(0,     0,   0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(1,     0,   0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(2,     1,   0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(3,     1,   0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(1279,  639, 0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(1280,  640, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(1311,  655, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(1312,  656, 0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp(1503,  751, 0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp(1504,  752, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(1599,  799, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(1600,  0,   1,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(9600,  0,   6,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(12799, 799, 7,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(12800, 0,   8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push_exp(15999, 799, 9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_exp(16000, 0,   10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(19199, 799, 11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(19200, 0,   0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        push_exp(19201, 0,   0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(38399, 799, 11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(38400, 0,   0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        push_exp(38401, 0,   0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        apply_stimulus();
        phase1  = 1'b1;
        running = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;

        wait_drain(45000);
        phase1 = 1'b0;
        check_output("hsync low clks in line 0", hs_low_cnt, 192);
        check_output("vsync low clks in frame 0", vs_low_cnt, 3200);
        check_output("frame_start pulses in two frames", fs_cnt, 2);

        // Mid-frame reset inside both retrace windows: pixel (700, 8).
        push_exp(52600, 700, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_edge(52600, 20000);
        #1 reset = 1'b1;
        push_exp(0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(2, 1, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        push_exp(3, 1, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #1 reset = 1'b0;
        wait_drain(100);

        check_output("video_on outside visible area", von_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
